// File: rtl/coarse_align_seq_if.sv
// Coarse-align sequencer bus: reference strobe, per-channel comparator inputs and
// per-channel pulse/status outputs. No handshake; all outputs are registered by the sequencer.
interface coarse_align_seq_if #(
    parameter int CHANNELS = 3
);
    logic                ref_tick;
    logic [CHANNELS-1:0] align_en;
    logic [CHANNELS-1:0] tlc;
    logic [CHANNELS-1:0] err_sign;
    logic [CHANNELS-1:0] adhi;
    logic [CHANNELS-1:0] up_pulse;
    logic [CHANNELS-1:0] dn_pulse;
    logic [CHANNELS-1:0] aligned;
    logic [CHANNELS-1:0] fail;
    logic                busy;

    modport master (
        output ref_tick, align_en, tlc, err_sign, adhi,
        input  up_pulse, dn_pulse, aligned, fail, busy
    );

    modport slave (
        input  ref_tick, align_en, tlc, err_sign, adhi,
        output up_pulse, dn_pulse, aligned, fail, busy
    );
endinterface

// File: rtl/coarse_align_seq.sv
// Per-channel coarse-align FSM: confirms persistent TLC on ref_tick, then drives rate-limited up/down pulses.
// Latency: async inputs 2 clk through synchronisers, outputs registered; no backpressure from the read counter.
module coarse_align_seq #(
    parameter int CHANNELS  = 3,
    parameter int CONFIRM   = 2,
    parameter int PULSE_DIV = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    coarse_align_seq_if.slave bus
);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam int DW = $clog2(PULSE_DIV);
    localparam int PW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_MONITOR,
        ST_DRIVE,
        ST_SETTLE,
        ST_FAIL
    } state_t;

    logic [CHANNELS-1:0] tlc_m, tlc_s;
    logic [CHANNELS-1:0] err_m, err_s;
    logic [CHANNELS-1:0] adhi_m, adhi_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlc_m  <= '0;
            tlc_s  <= '0;
            err_m  <= '0;
            err_s  <= '0;
            adhi_m <= '0;
            adhi_s <= '0;
        end else begin
            tlc_m  <= bus.tlc;
            tlc_s  <= tlc_m;
            err_m  <= bus.err_sign;
            err_s  <= err_m;
            adhi_m <= bus.adhi;
            adhi_s <= adhi_m;
        end
    end

    logic [CHANNELS-1:0] up_v, dn_v, aligned_v, fail_v, busy_v;
    logic                busy_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t        state, state_nxt;
        logic [CW-1:0] conf, conf_nxt;
        logic [DW-1:0] div, div_nxt;
        logic [PW-1:0] pcount, pcount_nxt;
        logic          dir, dir_nxt;
        logic          up_nxt, dn_nxt;
        logic          up_r, dn_r, aligned_r, fail_r;

        always_comb begin
            state_nxt  = state;
            conf_nxt   = conf;
            div_nxt    = div;
            pcount_nxt = pcount;
            dir_nxt    = dir;
            up_nxt     = 1'b0;
            dn_nxt     = 1'b0;
            if (!bus.align_en[g]) begin
                state_nxt  = ST_OFF;
                conf_nxt   = '0;
                div_nxt    = '0;
                pcount_nxt = '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        state_nxt  = ST_MONITOR;
                        conf_nxt   = '0;
                        pcount_nxt = '0;
                    end
                    ST_MONITOR: begin
                        if (bus.ref_tick) begin
                            if (!tlc_s[g]) begin
                                conf_nxt = '0;
                            end else if (conf == CW'(CONFIRM - 1)) begin
                                // ambiguity forces upward drive to escape the 180 degree null
                                state_nxt = ST_DRIVE;
                                conf_nxt  = '0;
                                div_nxt   = '0;
                                dir_nxt   = adhi_s[g] | err_s[g];
                            end else begin
                                conf_nxt = conf + 1'b1;
                            end
                        end
                    end
                    ST_DRIVE: begin
                        if (div == DW'(PULSE_DIV - 1)) begin
                            div_nxt    = '0;
                            pcount_nxt = pcount + 1'b1;
                            up_nxt     = dir;
                            dn_nxt     = ~dir;
                            if (pcount == PW'(TIMEOUT - 1))
                                state_nxt = ST_FAIL;
                        end else begin
                            div_nxt = div + 1'b1;
                        end
                        if (state_nxt == ST_DRIVE && bus.ref_tick && !tlc_s[g])
                            state_nxt = ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (bus.ref_tick) begin
                            if (tlc_s[g]) begin
                                state_nxt = ST_DRIVE;
                                div_nxt   = '0;
                                dir_nxt   = adhi_s[g] | err_s[g];
                            end else begin
                                state_nxt  = ST_MONITOR;
                                conf_nxt   = '0;
                                pcount_nxt = '0;
                            end
                        end
                    end
                    ST_FAIL: state_nxt = ST_FAIL;
                    default: state_nxt = ST_OFF;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= ST_OFF;
                conf      <= '0;
                div       <= '0;
                pcount    <= '0;
                dir       <= 1'b0;
                up_r      <= 1'b0;
                dn_r      <= 1'b0;
                aligned_r <= 1'b0;
                fail_r    <= 1'b0;
            end else begin
                state     <= state_nxt;
                conf      <= conf_nxt;
                div       <= div_nxt;
                pcount    <= pcount_nxt;
                dir       <= dir_nxt;
                up_r      <= up_nxt;
                dn_r      <= dn_nxt;
                aligned_r <= (state_nxt == ST_MONITOR) && (conf_nxt == '0);
                fail_r    <= (state_nxt == ST_FAIL);
            end
        end

        assign up_v[g]      = up_r;
        assign dn_v[g]      = dn_r;
        assign aligned_v[g] = aligned_r;
        assign fail_v[g]    = fail_r;
        assign busy_v[g]    = (state_nxt == ST_DRIVE) || (state_nxt == ST_SETTLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_r <= 1'b0;
        else        busy_r <= |busy_v;
    end

    assign bus.up_pulse = up_v;
    assign bus.dn_pulse = dn_v;
    assign bus.aligned  = aligned_v;
    assign bus.fail     = fail_v;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_coarse_align_seq.sv
// Bench for coarse_align_seq: scenario tasks against a time-indexed behavioural model
// (pulses scheduled from the DRIVE entry cycle rather than a divider counter).
module tb_coarse_align_seq;
    localparam int CH      = 3;
    localparam int CONFIRM = 2;
    localparam int PD      = 4;
    localparam int TO      = 5;
    localparam int TICK_P  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    coarse_align_seq_if #(.CHANNELS(CH)) bus();

    coarse_align_seq #(
        .CHANNELS(CH), .CONFIRM(CONFIRM), .PULSE_DIV(PD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int phase = 0;
    int cyc   = 0;

    typedef enum int {M_OFF, M_MON, M_DRV, M_SET, M_FAIL} mst_t;
    mst_t ms [CH];
    int   mconf [CH];
    int   mt0 [CH];
    int   mpc [CH];
    bit   mdir [CH];
    logic [CH-1:0] s1_t, s2_t, s1_e, s2_e, s1_a, s2_a;
    logic [CH-1:0] e_up, e_dn, e_al, e_fl;
    logic          e_busy;

    // Model: synchroniser is a two-deep delay of the sampled inputs; pulses fall every PD cycles after DRIVE entry.
    task automatic model_step();
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                ms[c] = M_OFF; mconf[c] = 0; mt0[c] = 0; mpc[c] = 0; mdir[c] = 1'b0;
            end
            s1_t = '0; s2_t = '0; s1_e = '0; s2_e = '0; s1_a = '0; s2_a = '0;
            e_up = '0; e_dn = '0; e_al = '0; e_fl = '0; e_busy = 1'b0;
        end else begin
            cyc++;
            e_busy = 1'b0;
            for (int c = 0; c < CH; c++) begin
                e_up[c] = 1'b0;
                e_dn[c] = 1'b0;
                if (!bus.align_en[c]) begin
                    ms[c] = M_OFF; mconf[c] = 0; mpc[c] = 0;
                end else begin
                    case (ms[c])
                        M_OFF: begin ms[c] = M_MON; mconf[c] = 0; mpc[c] = 0; end
                        M_MON: if (bus.ref_tick) begin
                            mconf[c] = s2_t[c] ? mconf[c] + 1 : 0;
                            if (mconf[c] == CONFIRM) begin
                                ms[c] = M_DRV; mt0[c] = cyc; mdir[c] = s2_a[c] | s2_e[c]; mconf[c] = 0;
                            end
                        end
                        M_DRV: begin
                            if ((cyc - mt0[c]) % PD == 0) begin
                                e_up[c] = mdir[c]; e_dn[c] = !mdir[c]; mpc[c]++;
                            end
                            if (mpc[c] == TO) ms[c] = M_FAIL;
                            else if (bus.ref_tick && !s2_t[c]) ms[c] = M_SET;
                        end
                        M_SET: if (bus.ref_tick) begin
                            if (s2_t[c]) begin
                                ms[c] = M_DRV; mt0[c] = cyc; mdir[c] = s2_a[c] | s2_e[c];
                            end else begin
                                ms[c] = M_MON; mconf[c] = 0; mpc[c] = 0;
                            end
                        end
                        default: ;
                    endcase
                end
                e_al[c] = (ms[c] == M_MON) && (mconf[c] == 0);
                e_fl[c] = (ms[c] == M_FAIL);
                if (ms[c] == M_DRV || ms[c] == M_SET) e_busy = 1'b1;
            end
            s2_t = s1_t; s1_t = bus.tlc;
            s2_e = s1_e; s1_e = bus.err_sign;
            s2_a = s1_a; s1_a = bus.adhi;
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    logic [4*CH:0] dut_o, exp_o;
    assign dut_o = {bus.up_pulse, bus.dn_pulse, bus.aligned, bus.fail, bus.busy};
    assign exp_o = {e_up, e_dn, e_al, e_fl, e_busy};

    task automatic cyc1();
        bus.ref_tick = (phase == 0);
        @(posedge clk);
        #1;
        phase = (phase + 1) % TICK_P;
    endtask

    task automatic sync_to_tick();
        for (int i = 0; i < TICK_P && phase != 1; i++) cyc1();
    endtask

    task automatic fresh(input logic [CH-1:0] en);
        bus.align_en = '0;
        cyc1();
        bus.align_en = en;
        cyc1();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_o !== '0) begin bad++; $display("FAIL reset_hold got=%h exp=0", dut_o); end
        bus.align_en = '1;
        @(posedge clk);
        #1;
        total++;
        if (dut_o !== '0) begin bad++; $display("FAIL reset_en got=%h exp=0", dut_o); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc1();
        total++;
        if (bus.aligned !== '1 || dut_o !== exp_o) begin
            bad++; $display("FAIL reset_release got=%h exp=%h", dut_o, exp_o);
        end
    endtask

    task automatic test_idle();
        int np = 0;
        bus.tlc = '0;
        for (int i = 0; i < 10 * TICK_P; i++) begin
            cyc1();
            np += $countones(bus.up_pulse | bus.dn_pulse);
            total++;
            if (dut_o !== exp_o) begin bad++; $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, dut_o, exp_o); end
        end
        total++;
        if (np != 0 || bus.aligned !== '1) begin
            bad++; $display("FAIL idle_quiet pulses=%0d aligned=%b exp 0/111", np, bus.aligned);
        end
    endtask

    task automatic test_drive();
        for (int it = 0; it < 3; it++) begin
            int first = -1;
            logic first_up = 1'b0;
            logic [CH-1:0] es = CH'($urandom);
            int len = $urandom_range(18, 28);
            fresh('1);
            sync_to_tick();
            bus.err_sign = es;
            bus.adhi = '0;
            bus.tlc = '1;
            for (int i = 0; i < len + 40; i++) begin
                if (i == len) bus.tlc = '0;
                cyc1();
                if (first < 0 && (bus.up_pulse[0] | bus.dn_pulse[0])) begin
                    first = cyc; first_up = bus.up_pulse[0];
                end
                total++;
                if (dut_o !== exp_o) begin bad++; $display("FAIL drive cyc=%0d got=%h exp=%h", cyc, dut_o, exp_o); end
            end
            total++;
            if (first - mt0[0] != PD || first_up !== es[0]) begin
                bad++; $display("FAIL drive_first delay=%0d up=%b exp delay=%0d up=%b", first - mt0[0], first_up, PD, es[0]);
            end
            total++;
            if (bus.aligned !== '1) begin bad++; $display("FAIL drive_settled aligned=%b exp=111", bus.aligned); end
        end
    endtask

    task automatic test_glitch();
        int np = 0;
        fresh('1);
        sync_to_tick();
        bus.tlc = '1;
        for (int i = 0; i < 4 * TICK_P; i++) begin
            if (i == TICK_P) bus.tlc = '0;
            cyc1();
            np += $countones(bus.up_pulse | bus.dn_pulse);
            total++;
            if (dut_o !== exp_o) begin bad++; $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, dut_o, exp_o); end
        end
        total++;
        if (np != 0 || bus.aligned !== '1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL glitch_quiet pulses=%0d aligned=%b busy=%b exp 0/111/0", np, bus.aligned, bus.busy);
        end
    endtask

    task automatic test_ambiguity();
        int nup = 0, ndn = 0;
        fresh('1);
        bus.adhi = '1;
        bus.err_sign = '0;
        bus.tlc = '1;
        for (int i = 0; i < 40; i++) begin
            cyc1();
            nup += $countones(bus.up_pulse);
            ndn += $countones(bus.dn_pulse);
            total++;
            if (dut_o !== exp_o) begin bad++; $display("FAIL ambig cyc=%0d got=%h exp=%h", cyc, dut_o, exp_o); end
        end
        total++;
        if (ndn != 0 || nup == 0) begin bad++; $display("FAIL ambig_dir up=%0d dn=%0d exp up>0 dn=0", nup, ndn); end
        bus.adhi = '0;
        bus.tlc = '0;
    endtask

    task automatic test_timeout();
        int np [CH];
        for (int c = 0; c < CH; c++) np[c] = 0;
        fresh('1);
        bus.err_sign = CH'($urandom);
        bus.tlc = '1;
        for (int i = 0; i < 60; i++) begin
            cyc1();
            for (int c = 0; c < CH; c++) np[c] += int'(bus.up_pulse[c] | bus.dn_pulse[c]);
            total++;
            if (dut_o !== exp_o) begin bad++; $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, dut_o, exp_o); end
        end
        for (int c = 0; c < CH; c++) begin
            total++;
            if (np[c] != TO) begin bad++; $display("FAIL timeout_count ch=%0d got=%0d exp=%0d", c, np[c], TO); end
        end
        total++;
        if (bus.fail !== '1) begin bad++; $display("FAIL timeout_flag got=%b exp=111", bus.fail); end
        bus.align_en = '0;
        bus.tlc = '0;
        cyc1();
        total++;
        if (bus.fail !== '0 || bus.aligned !== '0) begin
            bad++; $display("FAIL timeout_clear fail=%b aligned=%b exp 000/000", bus.fail, bus.aligned);
        end
        bus.align_en = '1;
        cyc1();
        total++;
        if (bus.aligned !== '1 || bus.fail !== '0) begin
            bad++; $display("FAIL timeout_reenable aligned=%b fail=%b exp 111/000", bus.aligned, bus.fail);
        end
    endtask

    task automatic test_multichannel();
        bit seen0 = 0, seen1 = 0, wrong = 0, hit = 0;
        fresh(3'b011);
        bus.err_sign = 3'b001;
        bus.adhi = '0;
        bus.tlc = '1;
        for (int i = 0; i < 80 && !hit; i++) begin
            cyc1();
            seen0 |= bus.up_pulse[0];
            seen1 |= bus.dn_pulse[1];
            wrong |= bus.dn_pulse[0] | bus.up_pulse[1] | bus.up_pulse[2] | bus.dn_pulse[2];
            total++;
            if (dut_o !== exp_o) begin bad++; $display("FAIL multi cyc=%0d got=%h exp=%h", cyc, dut_o, exp_o); end
            if (seen0 && ms[0] == M_DRV && ((cyc + 1 - mt0[0]) % PD == 0)) hit = 1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL multi_wait got=no_pulse_due exp=pulse_due"); end
        total++;
        if (!seen0 || !seen1 || wrong || bus.busy !== 1'b1) begin
            bad++; $display("FAIL multi_dirs up0=%b dn1=%b wrong=%b busy=%b exp 1/1/0/1", seen0, seen1, wrong, bus.busy);
        end
        bus.align_en = 3'b010;
        cyc1();
        total++;
        if (bus.up_pulse[0] !== 1'b0 || bus.dn_pulse[1] !== 1'b1 || dut_o !== exp_o) begin
            bad++; $display("FAIL multi_disable up0=%b dn1=%b exp 0/1 got=%h exp=%h", bus.up_pulse[0], bus.dn_pulse[1], dut_o, exp_o);
        end
        bus.tlc = '0;
    endtask

    task automatic test_random();
        fresh('1);
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 11) == 0) bus.tlc[c] = ~bus.tlc[c];
                if ($urandom_range(0, 7) == 0) bus.err_sign[c] = ~bus.err_sign[c];
                if ($urandom_range(0, 9) == 0) bus.adhi[c] = ~bus.adhi[c];
                if ($urandom_range(0, 49) == 0) bus.align_en[c] = ~bus.align_en[c];
            end
            cyc1();
            total++;
            if (dut_o !== exp_o) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_o, exp_o); end
        end
    endtask

    task automatic test_reset_mid_drive();
        bit in_drv = 0;
        fresh('1);
        bus.tlc = '1;
        bus.adhi = '0;
        for (int i = 0; i < 40 && !in_drv; i++) begin
            cyc1();
            in_drv = (ms[0] == M_DRV);
        end
        total++;
        if (!in_drv) begin bad++; $display("FAIL rst_drive_wait got=no_drive exp=drive"); end
        repeat (2) cyc1();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dut_o !== '0) begin bad++; $display("FAIL rst_async got=%h exp=0", dut_o); end
        @(posedge clk);
        #1;
        total++;
        if (dut_o !== '0) begin bad++; $display("FAIL rst_no_trailing got=%h exp=0", dut_o); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.tlc = '0;
        for (int i = 0; i < 20; i++) begin
            cyc1();
            total++;
            if (dut_o !== exp_o) begin bad++; $display("FAIL rst_after cyc=%0d got=%h exp=%h", cyc, dut_o, exp_o); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ref_tick = 1'b0;
        bus.align_en = '0;
        bus.tlc = '0;
        bus.err_sign = '0;
        bus.adhi = '0;
        test_reset();
        test_idle();
        test_drive();
        test_glitch();
        test_ambiguity();
        test_timeout();
        test_multichannel();
        test_random();
        test_reset_mid_drive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
